vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: one-cycle video fetch strobes (with a one-deep pending
// slot) take priority over level-handshaked CPU reads/writes.
module vram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic          vid_ovf,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_ready,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] V_ISS = 3'd1;
  localparam logic [2:0] V_DAT = 3'd2;
  localparam logic [2:0] C_ISS = 3'd3;
  localparam logic [2:0] C_DAT = 3'd4;

  logic [2:0]    r_state;
  logic          r_vid_pend;
  logic [AW-1:0] r_vid_addr_q;
  logic          r_cpu_we;
  logic          r_vid_done;
  logic          r_cpu_done;
  logic          w_vid_go;
  logic          w_cpu_go;

  assign cpu_ready = ~(cpu_req & ~cpu_ack);

  // A CPU grant waits until the previous result has been delivered; this also
  // keeps a still-held cpu_req from restarting before its ack is seen.
  always_comb begin
    w_vid_go = 1'b0;
    w_cpu_go = 1'b0;
    if (r_state == IDLE) begin
      w_vid_go = r_vid_pend | vid_req;
      w_cpu_go = ~w_vid_go & ~cpu_ready & ~r_vid_done & ~r_cpu_done;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_vid_pend   <= 1'b0;
      r_vid_addr_q <= '0;
      r_cpu_we     <= 1'b0;
      r_vid_done   <= 1'b0;
      r_cpu_done   <= 1'b0;
      vid_data     <= '0;
      vid_valid    <= 1'b0;
      vid_ovf      <= 1'b0;
      cpu_rdata    <= '0;
      cpu_ack      <= 1'b0;
      ram_addr     <= '0;
      ram_we       <= 1'b0;
      ram_wdata    <= '0;
    end else begin
      r_vid_done <= 1'b0;
      r_cpu_done <= 1'b0;
      vid_valid  <= r_vid_done;
      cpu_ack    <= r_cpu_done;
      ram_we     <= 1'b0;

      if (vid_req) begin
        r_vid_addr_q <= vid_addr;
        if (r_vid_pend && !w_vid_go)
          vid_ovf <= 1'b1;
      end

      // An issuing pending request is replaced by a coincident new strobe.
      if (w_vid_go)
        r_vid_pend <= r_vid_pend & vid_req;
      else if (vid_req)
        r_vid_pend <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_vid_go) begin
            r_state  <= V_ISS;
            ram_addr <= r_vid_pend ? r_vid_addr_q : vid_addr;
          end else if (w_cpu_go) begin
            r_state   <= C_ISS;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
            r_cpu_we  <= cpu_we;
          end
        end
        V_ISS: r_state <= V_DAT;
        C_ISS: begin
          r_state <= C_DAT;
          ram_we  <= r_cpu_we;
        end
        V_DAT: begin
          vid_data   <= ram_rdata;
          r_vid_done <= 1'b1;
          r_state    <= IDLE;
        end
        C_DAT: begin
          if (!r_cpu_we)
            cpu_rdata <= ram_rdata;
          r_cpu_done <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed accesses push expected returns,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_vram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_ovf;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_ovf(vid_ovf),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_ready(cpu_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous read-first RAM; contents preloaded once on the first reset.
  logic [DW-1:0] mem [0:1023];
  logic          preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[10'h155] <= 8'hA5;
      mem[10'h200] <= 8'h77;
      mem[10'h0AA] <= 8'h3C;
      mem[10'h3FF] <= 8'h99;
      mem[10'h020] <= 8'h11;
      preloaded    <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int c; logic [DW-1:0] data; } ret_t;
  typedef struct { int c; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int c; logic [AW-1:0] addr; } probe_t;

  ret_t   vid_q[$];
  ret_t   cpu_q[$];
  wr_t    wr_q[$];
  probe_t probe_q[$];
  ret_t   m_ret;
  wr_t    m_wr;
  probe_t m_pr;

  always @(negedge clk) begin
    if (vid_valid) begin
      if (vid_q.size() == 0) chk("vid_valid_unexpected", vid_valid, 0);
      else begin
        m_ret = vid_q.pop_front();
        chk("vid_data", vid_data, m_ret.data);
        chk("vid_valid_cycle", cyc, m_ret.c);
      end
    end
    if (cpu_ack) begin
      if (cpu_q.size() == 0) chk("cpu_ack_unexpected", cpu_ack, 0);
      else begin
        m_ret = cpu_q.pop_front();
        chk("cpu_rdata", cpu_rdata, m_ret.data);
        chk("cpu_ack_cycle", cyc, m_ret.c);
      end
    end
    if (ram_we) begin
      if (wr_q.size() == 0) chk("ram_we_unexpected", ram_we, 0);
      else begin
        m_wr = wr_q.pop_front();
        chk("ram_wr_addr", ram_addr, m_wr.addr);
        chk("ram_wr_data", ram_wdata, m_wr.data);
        chk("ram_wr_cycle", cyc, m_wr.c);
      end
    end
    if (probe_q.size() != 0 && probe_q[0].c == cyc) begin
      m_pr = probe_q.pop_front();
      chk("ram_addr_issue", ram_addr, m_pr.addr);
      chk("ram_we_on_issue", ram_we, 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_vid(input logic [DW-1:0] d, input int c);
    ret_t e; e.c = c; e.data = d; vid_q.push_back(e);
  endtask

  task automatic push_cpu(input logic [DW-1:0] d, input int c);
    ret_t e; e.c = c; e.data = d; cpu_q.push_back(e);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    wr_t e; e.c = c; e.addr = a; e.data = d; wr_q.push_back(e);
  endtask

  task automatic push_probe(input int c, input logic [AW-1:0] a);
    probe_t e; e.c = c; e.addr = a; probe_q.push_back(e);
  endtask

  task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  // Hold the request until ack is seen, then release it on the following cycle.
  task automatic cpu_wait_ack();
    int k = 0;
    while (!cpu_ack && k < 20) begin tick(); k++; end
    if (!cpu_ack) chk("cpu_ack_timeout", cpu_ack, 1);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    chk({tag, "_vid_data"},  vid_data, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_ram_addr"},  ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_ram_we"},    ram_we, 0);
    chk({tag, "_vid_valid"}, vid_valid, 0);
    chk({tag, "_cpu_ack"},   cpu_ack, 0);
    chk({tag, "_vid_ovf"},   vid_ovf, 0);
    chk({tag, "_cpu_ready"}, cpu_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    idle(3);
    reset = 1'b0;
    reset_checks("rst");

    // Lone video fetch from idle
    tick(); t0 = cyc;
    vid_req = 1'b1; vid_addr = 10'h155;
    push_vid(8'hA5, t0 + 4); push_probe(t0 + 1, 10'h155);
    tick(); vid_req = 1'b0;
    idle(8);
    chk("vid_ovf_single", vid_ovf, 0);

    // CPU write: stalls immediately, one write cycle, rdata untouched
    tick(); t0 = cyc;
    cpu_start(1'b1, 10'h3FF, 8'h5A);
    #1 chk("cpu_ready_stall", cpu_ready, 0);
    push_wr(10'h3FF, 8'h5A, t0 + 2); push_cpu(8'h00, t0 + 4);
    cpu_wait_ack();
    idle(6);
    chk("mem_3FF_written", mem[10'h3FF], 8'h5A);
    chk("cpu_ready_released", cpu_ready, 1);

    // CPU read back
    tick(); t0 = cyc;
    cpu_start(1'b0, 10'h3FF, 8'h00);
    push_probe(t0 + 1, 10'h3FF); push_cpu(8'h5A, t0 + 4);
    cpu_wait_ack();
    idle(6);

    // Simultaneous video and CPU read: video first
    tick(); t0 = cyc;
    vid_req = 1'b1; vid_addr = 10'h155;
    cpu_start(1'b0, 10'h3FF, 8'h00);
    push_vid(8'hA5, t0 + 4); push_probe(t0 + 1, 10'h155);
    push_probe(t0 + 5, 10'h3FF); push_cpu(8'h5A, t0 + 8);
    tick(); vid_req = 1'b0;
    cpu_wait_ack();
    idle(6);

    // Video behind an in-flight CPU read, then a strobe as the pending one issues
    tick(); t0 = cyc;
    cpu_start(1'b0, 10'h0AA, 8'h00);
    push_cpu(8'h3C, t0 + 4);
    tick(); vid_req = 1'b1; vid_addr = 10'h200; push_vid(8'h77, t0 + 7);
    tick(); vid_req = 1'b0;
    tick(); vid_req = 1'b1; vid_addr = 10'h0AA; push_vid(8'h3C, t0 + 10);
    tick(); vid_req = 1'b0;
    cpu_wait_ack();
    idle(10);
    chk("vid_ovf_reissue", vid_ovf, 0);

    // Two strobes while the CPU owns the RAM: overflow, only the second fetched
    tick(); t0 = cyc;
    cpu_start(1'b1, 10'h010, 8'hC3);
    push_wr(10'h010, 8'hC3, t0 + 2); push_cpu(8'h3C, t0 + 4);
    tick(); vid_req = 1'b1; vid_addr = 10'h155;
    tick(); vid_addr = 10'h200;
    tick(); vid_req = 1'b0;
    push_probe(t0 + 4, 10'h200); push_vid(8'h77, t0 + 7);
    cpu_wait_ack();
    idle(8);
    chk("vid_ovf_set", vid_ovf, 1);
    idle(3);
    chk("vid_ovf_sticky", vid_ovf, 1);
    chk("mem_010_written", mem[10'h010], 8'hC3);

    // Reset during C_ISS of a write aborts it
    tick(); t0 = cyc;
    cpu_start(1'b1, 10'h020, 8'hEE);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; cpu_req = 1'b0;
    reset_checks("abort");
    idle(8);
    chk("mem_020_kept", mem[10'h020], 8'h11);

    chk("vid_q_drained", vid_q.size(), 0);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("probe_q_drained", probe_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
